// File: rtl/gray_conv_sched.sv
// Shared binary/Gray conversion engine behind a round-robin scheduler.
// Bin->Gray finishes in one cycle; Gray->bin resolves one bit per cycle, MSB first.
module gray_conv_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_mode,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_mode,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SERIAL, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] gop;

  logic             found;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] sel_data;
  logic             sel_mode;
  logic             accept;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Rotating priority search, starting just after the last requester served.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int j = 1; j <= NREQ; j++) begin
      cand = IDW'((int'(ptr) + j) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[gidx] = 1'b1;
  end

  assign accept = (state == IDLE) && found;

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDW'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_mode = req_mode[i];
      end
    end
  end

  // Gray operand is only needed while the serial chain walks down the bits.
  always_ff @(posedge clk) begin
    if (accept) gop <= sel_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_mode  <= 1'b0;
      ptr       <= IDW'(NREQ - 1);
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr      <= gidx;
            rsp_id   <= gidx;
            rsp_mode <= sel_mode;
            if (!sel_mode) begin
              rsp_data  <= bin2gray(sel_data);
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_data <= {sel_data[WIDTH-1], {(WIDTH-1){1'b0}}};
              cnt      <= CW'(WIDTH - 2);
              state    <= SERIAL;
            end
          end
        end
        SERIAL: begin
          rsp_data[cnt] <= rsp_data[cnt + 1'b1] ^ gop[cnt];
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
